// File: rtl/banked_latency_memory.sv
// Shared word memory serving NUM_PORTS masters: round-robin grant, fixed LATENCY
// from grant to a one-cycle resp pulse, byte-masked writes, per-port read data.
module banked_latency_memory #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH_WORDS = 256,
  parameter int NUM_PORTS   = 2,
  parameter int LATENCY     = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_PORTS-1:0]                read,
  input  logic [NUM_PORTS-1:0]                write,
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] wmask,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]     wdata,
  output logic [NUM_PORTS-1:0]                resp,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]     rdata,
  output logic                                busy
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFFS  = $clog2(BYTES);
  localparam int IDXW  = $clog2(DEPTH_WORDS);
  localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW    = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                          state_q, state_d;
  logic [PW-1:0]                   last_q, last_d;
  logic [PW-1:0]                   port_q, port_d;
  logic                            wr_q, wr_d;
  logic                            both_q, both_d;
  logic [IDXW-1:0]                 idx_q, idx_d;
  logic [DATA_WIDTH-1:0]           wdata_q, wdata_d;
  logic [BYTES-1:0]                wmask_q, wmask_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic [NUM_PORTS-1:0]            resp_q, resp_d;
  logic                            busy_q, busy_d;
  logic [NUM_PORTS*DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0]           mem_q [DEPTH_WORDS];

  logic [NUM_PORTS-1:0]            req_s;
  logic                            found_s;
  logic [PW-1:0]                   gid_s;
  logic [PW-1:0]                   cand_s;
  logic [ADDR_WIDTH-1:0]           gaddr_s;
  logic                            commit_s;

  // Round-robin scan starting at the port after the last one granted
  always_comb begin
    req_s   = read | write;
    found_s = 1'b0;
    gid_s   = {PW{1'b0}};
    cand_s  = {PW{1'b0}};
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand_s = PW'((int'(last_q) + i) % NUM_PORTS);
      if (!found_s && req_s[cand_s]) begin
        found_s = 1'b1;
        gid_s   = cand_s;
      end else begin
        found_s = found_s;
      end
    end
    gaddr_s = address[gid_s*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Next state; commit_s marks the edge that enters RESP (uses the _d fields)
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    port_d   = port_q;
    wr_d     = wr_q;
    both_d   = both_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    cnt_d    = cnt_q;
    commit_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          port_d  = gid_s;
          last_d  = gid_s;
          wr_d    = write[gid_s];
          both_d  = write[gid_s] & read[gid_s];
          idx_d   = IDXW'(gaddr_s >> OFFS);
          wdata_d = wdata[gid_s*DATA_WIDTH +: DATA_WIDTH];
          wmask_d = wmask[gid_s*BYTES +: BYTES];
          if (LATENCY == 1) begin
            state_d  = RESP;
            commit_s = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(LATENCY - 1);
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == CW'(1)) begin
          state_d  = RESP;
          commit_s = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    for (int p = 0; p < NUM_PORTS; p++) begin
      resp_d[p] = commit_s && (port_d == PW'(p));
    end
    busy_d = (state_d != IDLE);
  end

  // Control, latched transaction and per-port read data registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= PW'(NUM_PORTS - 1);
      port_q  <= {PW{1'b0}};
      wr_q    <= 1'b0;
      both_q  <= 1'b0;
      idx_q   <= {IDXW{1'b0}};
      wdata_q <= {DATA_WIDTH{1'b0}};
      wmask_q <= {BYTES{1'b0}};
      cnt_q   <= {CW{1'b0}};
      resp_q  <= {NUM_PORTS{1'b0}};
      busy_q  <= 1'b0;
      rdata_q <= {(NUM_PORTS*DATA_WIDTH){1'b0}};
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      port_q  <= port_d;
      wr_q    <= wr_d;
      both_q  <= both_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      busy_q  <= busy_d;
      if (commit_s && !wr_d) begin
        rdata_q[port_d*DATA_WIDTH +: DATA_WIDTH] <= mem_q[idx_d];
      end else if (commit_s && both_d) begin
        rdata_q[port_d*DATA_WIDTH +: DATA_WIDTH] <= {DATA_WIDTH{1'b0}};
      end
    end
  end

  // Byte-masked write commit; contents survive reset, and reset blocks a commit
  always_ff @(posedge clk) begin
    if (commit_s && wr_d && !rst) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wmask_d[b]) begin
          mem_q[idx_d][b*8 +: 8] <= wdata_d[b*8 +: 8];
        end
      end
    end
  end

  assign resp  = resp_q;
  assign rdata = rdata_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_banked_latency_memory.sv
// Bench for banked_latency_memory: two instances (LATENCY 3 and 1) checked every
// cycle against a transaction-level model, plus directed literal expectations.
module tb_banked_latency_memory;
  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int DEPTH = 256;
  localparam int NP    = 2;
  localparam int NB    = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NP-1:0]    rd [2];
  logic [NP-1:0]    wr [2];
  logic [NP*NB-1:0] wm [2];
  logic [NP*AW-1:0] ad [2];
  logic [NP*DW-1:0] wd [2];
  logic [NP-1:0]    rs0, rs1;
  logic [NP*DW-1:0] rdt0, rdt1;
  logic             bsy0, bsy1;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  banked_latency_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_WORDS(DEPTH),
                          .NUM_PORTS(NP), .LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst), .read(rd[0]), .write(wr[0]), .wmask(wm[0]),
    .address(ad[0]), .wdata(wd[0]), .resp(rs0), .rdata(rdt0), .busy(bsy0));

  banked_latency_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_WORDS(DEPTH),
                          .NUM_PORTS(NP), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .read(rd[1]), .write(wr[1]), .wmask(wm[1]),
    .address(ad[1]), .wdata(wd[1]), .resp(rs1), .rdata(rdt1), .busy(bsy1));

  // Transaction-level model: a granted access completes LAT-1 edges after its
  // grant edge and the array is free again two edges after that.
  logic [DW-1:0] m_mem    [2][DEPTH];
  bit            m_val    [2][DEPTH];
  logic [DW-1:0] m_rdata  [2][NP];
  bit            m_rknown [2][NP];
  logic [NP-1:0] m_resp   [2];
  bit            m_busy   [2];
  bit            m_act    [2];
  bit            m_wr     [2];
  bit            m_both   [2];
  int            m_last   [2];
  int            m_commit [2];
  int            m_port   [2];
  int            m_idx    [2];
  logic [DW-1:0] m_wd     [2];
  logic [NB-1:0] m_wm     [2];

  bit pend  [2][NP];
  int waitc [2][NP];
  int ev_port [$];
  int ev_cyc  [$];

  function automatic int lat(input int k);
    return (k == 0) ? 3 : 1;
  endfunction

  function automatic logic [NP-1:0] dut_resp(input int k);
    return (k == 0) ? rs0 : rs1;
  endfunction

  function automatic logic dut_busy(input int k);
    return (k == 0) ? bsy0 : bsy1;
  endfunction

  function automatic logic [DW-1:0] dut_rd_port(input int k, input int p);
    logic [NP*DW-1:0] v;
    v = (k == 0) ? rdt0 : rdt1;
    return v[p*DW +: DW];
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", name, k, cyc, got, exp);
    end
  endtask

  task automatic model_step(input int k);
    logic [NP-1:0] req;
    m_resp[k] = '0;
    if (rst) begin
      m_act[k]  = 1'b0;
      m_busy[k] = 1'b0;
      m_last[k] = NP - 1;
      for (int p = 0; p < NP; p++) begin
        m_rdata[k][p]  = '0;
        m_rknown[k][p] = 1'b1;
      end
      return;
    end
    req = rd[k] | wr[k];
    if (m_act[k] && cyc == m_commit[k] + 1) begin
      m_act[k] = 1'b0;
    end else if (!m_act[k] && req != '0) begin
      for (int i = 1; i <= NP; i++) begin
        int c;
        c = (m_last[k] + i) % NP;
        if (req[c]) begin
          m_port[k]   = c;
          m_last[k]   = c;
          m_wr[k]     = wr[k][c];
          m_both[k]   = wr[k][c] & rd[k][c];
          m_idx[k]    = (int'(ad[k][c*AW +: AW]) / NB) % DEPTH;
          m_wd[k]     = wd[k][c*DW +: DW];
          m_wm[k]     = wm[k][c*NB +: NB];
          m_commit[k] = cyc + lat(k) - 1;
          m_act[k]    = 1'b1;
          break;
        end
      end
    end
    if (m_act[k] && cyc == m_commit[k]) begin
      if (m_wr[k]) begin
        for (int b = 0; b < NB; b++)
          if (m_wm[k][b]) m_mem[k][m_idx[k]][b*8 +: 8] = m_wd[k][b*8 +: 8];
        if (m_wm[k] == {NB{1'b1}}) m_val[k][m_idx[k]] = 1'b1;
        if (m_both[k]) begin
          m_rdata[k][m_port[k]]  = '0;
          m_rknown[k][m_port[k]] = 1'b1;
        end
      end else begin
        m_rdata[k][m_port[k]]  = m_mem[k][m_idx[k]];
        m_rknown[k][m_port[k]] = m_val[k][m_idx[k]];
      end
      m_resp[k][m_port[k]] = 1'b1;
    end
    m_busy[k] = m_act[k] && (cyc <= m_commit[k]);
  endtask

  // Every-cycle comparison of both instances against the model
  always @(posedge clk) begin
    cyc = cyc + 1;
    model_step(0);
    model_step(1);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("resp", k, dut_resp(k), m_resp[k]);
      chk("busy", k, dut_busy(k), m_busy[k]);
      for (int p = 0; p < NP; p++)
        if (m_rknown[k][p]) chk("rdata", k, dut_rd_port(k, p), m_rdata[k][p]);
    end
  end

  task automatic set_port(input int k, input int p, input bit r, input bit w,
                          input logic [15:0] a, input logic [15:0] d, input logic [1:0] m);
    rd[k][p]            = r;
    wr[k][p]            = w;
    ad[k][p*AW +: AW]   = a;
    wd[k][p*DW +: DW]   = d;
    wm[k][p*NB +: NB]   = m;
  endtask

  task automatic wait_any(input int k, output logic [NP-1:0] got, output int n);
    got = '0;
    n   = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (dut_resp(k) != '0) begin
        got = dut_resp(k);
        break;
      end
    end
  endtask

  // One isolated access from an idle array; returns read data and cycles to resp
  task automatic txn(input int k, input int p, input bit r, input bit w,
                     input logic [15:0] a, input logic [15:0] d, input logic [1:0] m,
                     output logic [15:0] q, output int n);
    logic [NP-1:0] got;
    set_port(k, p, r, w, a, d, m);
    wait_any(k, got, n);
    chk("txn_port", k, got, NP'(1) << p);
    q = dut_rd_port(k, p);
    rd[k][p] = 1'b0;
    wr[k][p] = 1'b0;
    @(negedge clk);
  endtask

  task automatic drive(input int k, input int p);
    logic [NP-1:0] r;
    int op;
    r = dut_resp(k);
    if (pend[k][p]) begin
      waitc[k][p]++;
      if (r[p] || waitc[k][p] > NP * (lat(k) + 1)) begin
        chk("fair_wait", k, waitc[k][p] <= NP * (lat(k) + 1), 1);
        pend[k][p] = 1'b0;
        rd[k][p]   = 1'b0;
        wr[k][p]   = 1'b0;
      end
    end else if ($urandom_range(0, 2) == 0) begin
      op = $urandom_range(0, 9);
      set_port(k, p, (op <= 3) || (op == 9), op >= 4,
               16'($urandom_range(0, 15) * 2 + $urandom_range(0, 1) +
                   (($urandom_range(0, 3) == 0) ? 512 * $urandom_range(1, 3) : 0)),
               16'($urandom), 2'($urandom_range(0, 3)));
      pend[k][p]  = 1'b1;
      waitc[k][p] = 0;
    end
  endtask

  initial begin
    logic [15:0]   q;
    logic [NP-1:0] got;
    int            n;

    for (int k = 0; k < 2; k++) begin
      rd[k] = '0; wr[k] = '0; wm[k] = '0; ad[k] = '0; wd[k] = '0;
    end

    // Reset with a read pending, then port 0 wins the first grant
    rd[0] = 2'b01;
    repeat (2) @(negedge clk);
    chk("rst_resp", 0, rs0, 2'b00);
    chk("rst_rdata", 0, rdt0, 32'h0);
    chk("rst_busy", 0, bsy0, 1'b0);
    set_port(0, 0, 1'b1, 1'b0, 16'h0010, 16'h0, 2'b00);
    set_port(0, 1, 1'b1, 1'b0, 16'h0000, 16'h0, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    wait_any(0, got, n);
    chk("first_grant", 0, got, 2'b01);
    chk("first_lat", 0, n, 3);
    rd[0][0] = 1'b0;
    wait_any(0, got, n);
    chk("second_grant", 0, got, 2'b10);
    chk("second_gap", 0, n, 4);
    rd[0][1] = 1'b0;
    @(negedge clk);

    // Full write, read back
    txn(0, 0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, q, n);
    chk("wr_lat", 0, n, 3);
    txn(0, 0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, q, n);
    chk("rd_lat", 0, n, 3);
    chk("rd_beef", 0, q, 16'hBEEF);

    // Byte masks from port 1
    txn(0, 1, 1'b0, 1'b1, 16'h0010, 16'h12AB, 2'b01, q, n);
    txn(0, 1, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, q, n);
    chk("mask_lo", 0, q, 16'hBEAB);
    txn(0, 1, 1'b0, 1'b1, 16'h0011, 16'h3400, 2'b10, q, n);
    txn(0, 0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, q, n);
    chk("mask_hi", 0, q, 16'h34AB);

    // Aliasing above DEPTH_WORDS
    txn(0, 0, 1'b0, 1'b1, 16'h0200, 16'h5A5A, 2'b11, q, n);
    txn(0, 1, 1'b1, 1'b0, 16'h0000, 16'h0000, 2'b00, q, n);
    chk("alias", 0, q, 16'h5A5A);

    // Read and write together act as a write with zero read data
    txn(0, 0, 1'b1, 1'b1, 16'h0020, 16'h1111, 2'b11, q, n);
    chk("rw_zero", 0, q, 16'h0000);
    txn(0, 1, 1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, q, n);
    chk("rw_commit", 0, q, 16'h1111);

    // Request dropped after grant still completes
    set_port(0, 1, 1'b1, 1'b0, 16'h0000, 16'h0, 2'b00);
    @(negedge clk);
    rd[0][1] = 1'b0;
    wait_any(0, got, n);
    chk("drop_resp", 0, got, 2'b10);
    chk("drop_lat", 0, n, 2);
    chk("drop_data", 0, dut_rd_port(0, 1), 16'h5A5A);
    @(negedge clk);

    // Both ports requesting continuously
    set_port(0, 0, 1'b1, 1'b0, 16'h0010, 16'h0, 2'b00);
    set_port(0, 1, 1'b1, 1'b0, 16'h0000, 16'h0, 2'b00);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rs0 != '0) begin
        ev_port.push_back(rs0[1] ? 1 : 0);
        ev_cyc.push_back(cyc);
      end
    end
    rd[0] = '0;
    chk("cont_count", 0, ev_port.size() >= 6, 1);
    for (int i = 1; i < ev_port.size() && i < 6; i++) begin
      chk("cont_alt", 0, ev_port[i] != ev_port[i-1], 1);
      chk("cont_gap", 0, ev_cyc[i] - ev_cyc[i-1], 4);
    end
    repeat (6) @(negedge clk);

    // LATENCY = 1 instance
    txn(1, 0, 1'b0, 1'b1, 16'h0004, 16'hC3C3, 2'b11, q, n);
    chk("l1_wr_lat", 1, n, 1);
    txn(1, 1, 1'b1, 1'b0, 16'h0004, 16'h0000, 2'b00, q, n);
    chk("l1_rd_lat", 1, n, 1);
    chk("l1_data", 1, q, 16'hC3C3);

    // Reset during WAIT aborts the write
    set_port(0, 0, 1'b0, 1'b1, 16'h0010, 16'hFFFF, 2'b11);
    @(negedge clk);
    chk("wait_busy", 0, bsy0, 1'b1);
    rst = 1'b1;
    wr[0] = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_resp", 0, rs0, 2'b00);
      chk("abort_busy", 0, bsy0, 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    txn(0, 0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, q, n);
    chk("abort_lat", 0, n, 3);
    chk("abort_keep", 0, q, 16'h34AB);

    // Randomised traffic on both instances with one reset in the middle
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c == 1500) begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
          rd[k] = '0;
          wr[k] = '0;
          for (int p = 0; p < NP; p++) pend[k][p] = 1'b0;
        end
      end else if (c == 1503) begin
        rst = 1'b0;
      end else if (!rst) begin
        for (int k = 0; k < 2; k++)
          for (int p = 0; p < NP; p++) drive(k, p);
      end
    end
    for (int k = 0; k < 2; k++) begin
      rd[k] = '0;
      wr[k] = '0;
    end
    repeat (8) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/banked_latency_memory.md
Name: banked_latency_memory

Overview:
- Parametrised, synthesizable successor to the single-port magic memory used by the mp3 bench.
- Serves NUM_PORTS independent masters, such as split I-side and D-side ports, from one shared word array.
- Arbitrates among ports round-robin and answers each request after a programmable fixed LATENCY, using the same read/write/resp hold-until-response protocol.
- Sits between the CPU (or its caches) and the bench, so stall and arbitration paths can be exercised.

Parameters:
- DATA_WIDTH, 16, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 16, byte-address width per port.
- DEPTH_WORDS, 256, number of words in the array; must be a power of 2.
- NUM_PORTS, 2, number of requesting masters, 1..8.
- LATENCY, 3, cycles from the grant cycle to the resp cycle, >= 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- read  in  NUM_PORTS  per-port read request, level, held until resp.
- write  in  NUM_PORTS  per-port write request, level, held until resp.
- wmask  in  NUM_PORTS*DATA_WIDTH/8  per-port byte enables; port p uses slice p.
- address  in  NUM_PORTS*ADDR_WIDTH  per-port byte address.
- wdata  in  NUM_PORTS*DATA_WIDTH  per-port write data.
- resp  out  NUM_PORTS  one-cycle completion pulse per port.
- rdata  out  NUM_PORTS*DATA_WIDTH  per-port registered read data; valid in the resp cycle.
- busy  out  1  high while a transaction is in flight (WAIT or RESP state).

Behaviour:
- Reset (async): FSM to IDLE; resp=0, rdata=0, busy=0; round-robin pointer last=NUM_PORTS-1, so port 0 has priority first. Array contents are not cleared.
- Addressing:
  - word index = address >> log2(DATA_WIDTH/8), truncated mod DEPTH_WORDS, so high address bits alias.
  - Low byte-offset bits are ignored.
- A port is requesting when read|write is high. If read and write are both high, the access is treated as a write and that port's rdata is set to 0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If any port is requesting, grant the first requesting port scanning from last+1 with wrap.
  - Latch port id, op, word index, wdata and wmask; set last=granted id.
  - If LATENCY==1 go to RESP; else load counter=LATENCY-1 and go to WAIT.
  - No request: stay in IDLE.
- WAIT: decrement counter; leave for RESP when the counter reaches 1. Inputs are ignored.
- Entering RESP (the edge out of IDLE/WAIT):
  - Write: commit the latched wdata for bytes with wmask=1; other bytes are unchanged.
  - Read: the array word is registered into rdata[granted].
- RESP: resp[granted]=1 for exactly this cycle; all other resp bits are 0. Next state is always IDLE, so a request still high in RESP is never re-granted.
- Timing: resp asserts exactly LATENCY cycles after the grant cycle. Peak throughput is one access per LATENCY+1 cycles.
- Data hold and visibility:
  - rdata for each port holds its last read value until that port's next read completes.
  - A read always sees every write committed before it, regardless of the writing port.
- Request dropped before resp (protocol violation): the latched transaction still completes and resp still pulses.
- Reset mid-transaction: the transaction is aborted, no resp is issued, and an uncommitted write has no effect.
- Non-granted requesters wait with no timeout. Fairness bound: a port waits at most (NUM_PORTS-1) transactions.

Test Plan:
1. Assert rst while read[0]=1 -> resp=0, rdata=0, busy=0; after release, port 0 is granted first.
2. NUM_PORTS=2, LATENCY=3: port0 writes 0xBEEF to 0x0010, mask 2'b11, granted at cycle 0 -> resp[0] at cycle 3 only. Then a port0 read of 0x0010 -> resp[0] at cycle 3 with rdata[0]=0xBEEF.
3. Byte mask: port1 writes 0x12AB to 0x0010 with mask 2'b01, then reads -> 0xBEAB; 0x0011 with mask 2'b10 writes the high byte only.
4. Ports 0 and 1 request continuously, each issuing a new request after every resp -> grants alternate 0,1,0,1; resp pulses 4 cycles apart (LATENCY=3).
5. Alias: write 0x5A5A to 0x0200 with DEPTH_WORDS=256 -> a read of 0x0000 returns 0x5A5A.
6. LATENCY=1: write then read 0x0004 -> each resp one cycle after grant; then assert rst during WAIT of a LATENCY=3 write of 0xFFFF -> no resp, and a read of that address after reset returns the old value.
